// File: rtl/line_raster_engine.sv
// Bresenham line rasteriser: takes one line command and emits every pixel,
// endpoints inclusive, as {y,x} address / colour beats on a back-pressurable stream.
module line_raster_engine #(
   parameter int X_W     = 8,
   parameter int Y_W     = 8,
   parameter int COLOR_W = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             cmd_valid,
   output logic                             cmd_ready,
   input  logic [X_W-1:0]                   x0,
   input  logic [X_W-1:0]                   x1,
   input  logic [Y_W-1:0]                   y0,
   input  logic [Y_W-1:0]                   y1,
   input  logic [COLOR_W-1:0]               color,
   input  logic                             abort,
   output logic                             px_valid,
   input  logic                             px_ready,
   output logic [X_W+Y_W-1:0]               fb_addr,
   output logic [COLOR_W-1:0]               fb_data,
   output logic                             busy,
   output logic                             done,
   output logic [((X_W > Y_W) ? X_W : Y_W):0] px_count
);

   localparam int W = (X_W > Y_W) ? X_W : Y_W;

   typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

   state_t              state, state_nxt;
   logic [X_W-1:0]      x0_q, x1_q, cur_x;
   logic [Y_W-1:0]      y0_q, y1_q, cur_y;
   logic [COLOR_W-1:0]  color_q;
   logic [W-1:0]        adx, ady;
   logic                x_dec, y_dec;
   logic signed [W+1:0] err, err_nxt;
   logic signed [W+2:0] e2;
   logic [X_W-1:0]      dx_abs;
   logic [Y_W-1:0]      dy_abs;
   logic                step_x, step_y, beat, last;

   assign beat   = px_valid & px_ready;
   assign last   = (cur_x == x1_q) && (cur_y == y1_q);
   assign dx_abs = (x1_q >= x0_q) ? x1_q - x0_q : x0_q - x1_q;
   assign dy_abs = (y1_q >= y0_q) ? y1_q - y0_q : y0_q - y1_q;

   // NOTE: combinational blocks use blocking '=' and assign every output a default
   // first, so no latch is inferred; clocked state below uses non-blocking '<='.
   always_comb begin
      e2      = {err, 1'b0};
      step_x  = e2 > -$signed({3'b000, ady});
      step_y  = e2 < $signed({3'b000, adx});
      err_nxt = err;
      if (step_x) err_nxt = err_nxt - $signed({2'b00, ady});
      if (step_y) err_nxt = err_nxt + $signed({2'b00, adx});
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_valid) state_nxt = SETUP;
         SETUP:   state_nxt = abort ? IDLE : DRAW;
         // completion takes priority over a simultaneous abort
         DRAW:    if ((beat && last) || abort) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state == IDLE);
      px_valid  = (state == DRAW);
      busy      = (state != IDLE);
   end

   assign fb_addr = {cur_y, cur_x};
   assign fb_data = color_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         x0_q     <= '0;
         x1_q     <= '0;
         y0_q     <= '0;
         y1_q     <= '0;
         color_q  <= '0;
         cur_x    <= '0;
         cur_y    <= '0;
         adx      <= '0;
         ady      <= '0;
         x_dec    <= 1'b0;
         y_dec    <= 1'b0;
         err      <= '0;
         px_count <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  x0_q     <= x0;
                  x1_q     <= x1;
                  y0_q     <= y0;
                  y1_q     <= y1;
                  color_q  <= color;
                  px_count <= '0;
               end
            end
            SETUP: begin
               adx   <= W'(dx_abs);
               ady   <= W'(dy_abs);
               x_dec <= (x1_q < x0_q);
               y_dec <= (y1_q < y0_q);
               err   <= $signed({2'b00, W'(dx_abs)}) - $signed({2'b00, W'(dy_abs)});
               cur_x <= x0_q;
               cur_y <= y0_q;
            end
            DRAW: begin
               if (beat) begin
                  px_count <= px_count + (W+1)'(1);
                  if (last) begin
                     done <= 1'b1;
                  end else begin
                     err <= err_nxt;
                     if (step_x) cur_x <= x_dec ? cur_x - X_W'(1) : cur_x + X_W'(1);
                     if (step_y) cur_y <= y_dec ? cur_y - Y_W'(1) : cur_y + Y_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
